// File: rtl/bit_cldiv_pkg.sv
// Shared types and helpers for the carry-less divide unit.
// Holds the handshake structs, the register record and its reset value,
// the state encoding and the leading-one helper used to find deg(b).
package bit_cldiv_pkg;

  localparam int unsigned CLDIV_XLEN  = 32;
  localparam int unsigned CLDIV_CNT_W = $clog2(CLDIV_XLEN);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } bit_cldiv_state_e;

  // Bit-manipulation op flags for the divide path.
  typedef struct packed {
    logic bit_cldiv;
    logic bit_clrem;
  } bit_op_type;

  typedef struct packed {
    logic                  enable;
    bit_op_type            op;
    logic [CLDIV_XLEN-1:0] rdata1;
    logic [CLDIV_XLEN-1:0] rdata2;
  } bit_cldiv_in_type;

  typedef struct packed {
    logic [CLDIV_XLEN-1:0] result;
    logic                  ready;
  } bit_cldiv_out_type;

  typedef struct packed {
    bit_cldiv_state_e       state;
    logic [CLDIV_CNT_W-1:0] counter;
    logic [CLDIV_CNT_W-1:0] deg;
    bit_op_type             op;
    logic [CLDIV_XLEN-1:0]  a;
    logic [CLDIV_XLEN-1:0]  b;
    logic [CLDIV_XLEN-1:0]  quotient;
    logic [CLDIV_XLEN-1:0]  remainder;
    logic [CLDIV_XLEN-1:0]  result;
    logic                   ready;
  } bit_cldiv_reg_type;

  localparam bit_cldiv_reg_type init_bit_cldiv_reg = '{
    state:     IDLE,
    counter:   '0,
    deg:       '0,
    op:        '0,
    a:         '0,
    b:         '0,
    quotient:  '0,
    remainder: '0,
    result:    '0,
    ready:     1'b0
  };

  // Index of the most significant set bit; 0 for a zero input.
  function automatic logic [CLDIV_CNT_W-1:0] lead_one(input logic [CLDIV_XLEN-1:0] v);
    lead_one = '0;
    for (int unsigned i = 0; i < CLDIV_XLEN; i++) begin
      if (v[i]) lead_one = CLDIV_CNT_W'(i);
    end
  endfunction

endpackage

// File: rtl/bit_cldiv.sv
// Iterative carry-less (GF(2) polynomial) divider, one dividend bit per
// cycle, MSB first. Returns quotient (op_div) or remainder (op_rem) of
// rdata1 / rdata2.
//   clock   : rising-edge clock
//   reset   : synchronous, active-low
//   enable  : start request, only honoured in IDLE
//   op_div  : request quotient (wins if both op bits set)
//   op_rem  : request remainder
//   rdata1  : dividend a
//   rdata2  : divisor b (b==0 yields quotient 0, remainder a)
//   result  : result of the last completed operation, held until the next
//   ready   : one-cycle completion pulse, coincident with the DONE state
module bit_cldiv
  import bit_cldiv_pkg::*;
#(
  // Internal record widths come from CLDIV_XLEN; keep the two equal.
  parameter int unsigned XLEN = CLDIV_XLEN
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            enable,
  input  logic            op_div,
  input  logic            op_rem,
  input  logic [XLEN-1:0] rdata1,
  input  logic [XLEN-1:0] rdata2,
  output logic [XLEN-1:0] result,
  output logic            ready
);

  bit_cldiv_in_type  in_s;
  bit_cldiv_out_type out_s;
  bit_cldiv_reg_type r_q, r_d;

  logic [XLEN-1:0] step_rem;
  logic [XLEN-1:0] step_quo;

  assign in_s.enable       = enable;
  assign in_s.op.bit_cldiv = op_div;
  assign in_s.op.bit_clrem = op_rem;
  assign in_s.rdata1       = rdata1;
  assign in_s.rdata2       = rdata2;

  always_comb begin
    r_d      = r_q;
    r_d.ready = 1'b0;
    step_rem = '0;
    step_quo = '0;

    unique case (r_q.state)
      IDLE: begin
        if (in_s.enable && (in_s.op.bit_cldiv || in_s.op.bit_clrem)) begin
          r_d.op.bit_cldiv = in_s.op.bit_cldiv;
          r_d.op.bit_clrem = ~in_s.op.bit_cldiv;
          r_d.a            = in_s.rdata1;
          r_d.b            = in_s.rdata2;
          r_d.deg          = lead_one(in_s.rdata2);
          r_d.counter      = CLDIV_CNT_W'(CLDIV_XLEN - 1);
          r_d.quotient     = '0;
          r_d.remainder    = '0;
          if (in_s.rdata2 == '0) begin
            // Divide by zero: skip iteration, remainder is the dividend.
            r_d.state     = DONE;
            r_d.remainder = in_s.rdata1;
            r_d.ready     = 1'b1;
            r_d.result    = in_s.op.bit_cldiv ? '0 : in_s.rdata1;
          end else begin
            r_d.state = CALC;
          end
        end
      end

      CALC: begin
        // Shift in the next dividend bit; deg(rem) < d beforehand, so
        // bit d is the only bit that can need cancelling by b.
        step_rem = {r_q.remainder[XLEN-2:0], r_q.a[r_q.counter]};
        step_quo = r_q.quotient;
        if (step_rem[r_q.deg]) begin
          step_rem             = step_rem ^ r_q.b;
          step_quo[r_q.counter] = 1'b1;
        end
        r_d.remainder = step_rem;
        r_d.quotient  = step_quo;
        if (r_q.counter == '0) begin
          // ready/result register on entry to DONE so they are visible
          // during the DONE cycle itself.
          r_d.state  = DONE;
          r_d.ready  = 1'b1;
          r_d.result = r_q.op.bit_cldiv ? step_quo :
                       (r_q.op.bit_clrem ? step_rem : '0);
        end else begin
          r_d.counter = r_q.counter - 1'b1;
        end
      end

      DONE: begin
        r_d.state = IDLE;
      end

      default: begin
        r_d.state = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_q <= init_bit_cldiv_reg;
    end else begin
      r_q <= r_d;
    end
  end

  assign out_s.result = r_q.result;
  assign out_s.ready  = r_q.ready;
  assign result       = out_s.result;
  assign ready        = out_s.ready;

endmodule

// File: tb/tb_bit_cldiv.sv
// Directed + random bench for bit_cldiv with a result scoreboard.
module tb_bit_cldiv;

  localparam int unsigned XLEN = 32;

  logic            clock = 1'b0;
  logic            reset;
  logic            enable;
  logic            op_div;
  logic            op_rem;
  logic [XLEN-1:0] rdata1;
  logic [XLEN-1:0] rdata2;
  logic [XLEN-1:0] result;
  logic            ready;

  bit_cldiv #(.XLEN(XLEN)) dut (
    .clock  (clock),
    .reset  (reset),
    .enable (enable),
    .op_div (op_div),
    .op_rem (op_rem),
    .rdata1 (rdata1),
    .rdata2 (rdata2),
    .result (result),
    .ready  (ready)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int passes = 0;
  int total  = 0;
  int acc_cyc = 0;

  typedef struct {
    logic [XLEN-1:0] res;
    int              lat;
  } exp_t;
  exp_t sb[$];

  task automatic check(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  function automatic int deg(input logic [XLEN-1:0] v);
    deg = -1;
    for (int i = 0; i < XLEN; i++) if (v[i]) deg = i;
  endfunction

  function automatic logic [XLEN-1:0] clmul(input logic [XLEN-1:0] x, input logic [XLEN-1:0] y);
    clmul = '0;
    for (int i = 0; i < XLEN; i++) if (y[i]) clmul = clmul ^ (x << i);
  endfunction

  // Schoolbook polynomial long division, top degree down.
  function automatic logic [XLEN-1:0] model(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                                            input logic div);
    logic [XLEN-1:0] q, r;
    int db;
    if (b == '0) return div ? '0 : a;
    q  = '0;
    r  = a;
    db = deg(b);
    for (int i = XLEN - 1; i >= db; i--) begin
      if (r[i]) begin
        r = r ^ (b << (i - db));
        q[i - db] = 1'b1;
      end
    end
    return div ? q : r;
  endfunction

  // Called just after a rising edge; enable is sampled at the next edge.
  task automatic start(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                       input logic div, input logic rem);
    rdata1  = a;
    rdata2  = b;
    op_div  = div;
    op_rem  = rem;
    enable  = 1'b1;
    acc_cyc = cyc;
    @(posedge clock); #1;
    enable = 1'b0;
    op_div = 1'b0;
    op_rem = 1'b0;
    rdata1 = $urandom;
    rdata2 = $urandom;
  endtask

  task automatic finish_op(input string tag, output logic [XLEN-1:0] got);
    exp_t e;
    bit   seen;
    int   lat;
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (ready === 1'b1) begin
        seen = 1'b1;
        break;
      end
      @(posedge clock); #1;
    end
    lat = cyc - acc_cyc;
    check({tag, "_ready_seen"}, 32'(seen), 32'd1);
    e = sb.pop_front();
    check({tag, "_result"}, result, e.res);
    check({tag, "_latency"}, 32'(lat), 32'(e.lat));
    got = result;
    @(posedge clock); #1;
    check({tag, "_ready_pulse"}, 32'(ready), 32'd0);
    check({tag, "_result_hold"}, result, e.res);
  endtask

  task automatic run_op(input string tag, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                        input logic div, output logic [XLEN-1:0] got);
    exp_t e;
    e.res = model(a, b, div);
    e.lat = (b == '0) ? 1 : 33;
    start(a, b, div, ~div);
    sb.push_back(e);
    finish_op(tag, got);
  endtask

  task automatic count_ready(input int n, output int cnt);
    cnt = 0;
    for (int k = 0; k < n; k++) begin
      @(posedge clock); #1;
      if (ready === 1'b1) cnt++;
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [XLEN-1:0] got, q, r, a, b;
    exp_t e;
    int cnt;
    int prev_acc;
    bit have_prev;

    reset  = 1'b0;
    enable = 1'b0;
    op_div = 1'b0;
    op_rem = 1'b0;
    rdata1 = '0;
    rdata2 = '0;
    repeat (3) @(posedge clock);
    #1;
    check("reset_ready", 32'(ready), 32'd0);
    check("reset_result", result, '0);
    reset = 1'b1;
    @(posedge clock); #1;

    run_op("div_11_3", 32'h0000_0011, 32'h0000_0003, 1'b1, got);
    run_op("rem_11_3", 32'h0000_0011, 32'h0000_0003, 1'b0, got);
    run_op("div_13_3", 32'h0000_0013, 32'h0000_0003, 1'b1, got);
    run_op("rem_13_3", 32'h0000_0013, 32'h0000_0003, 1'b0, got);
    run_op("div_by1", 32'hDEAD_BEEF, 32'h0000_0001, 1'b1, got);
    run_op("rem_by1", 32'hDEAD_BEEF, 32'h0000_0001, 1'b0, got);
    run_op("div_msb", 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, got);
    run_op("rem_msb", 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, got);
    run_op("div_by0", 32'h1234_5678, 32'h0000_0000, 1'b1, got);
    run_op("rem_by0", 32'h1234_5678, 32'h0000_0000, 1'b0, got);

    // Both op bits set: quotient wins.
    e.res = 32'h0000_000E;
    e.lat = 33;
    start(32'h0000_0013, 32'h0000_0003, 1'b1, 1'b1);
    sb.push_back(e);
    finish_op("both_ops", got);

    // Enable without an op bit is ignored.
    start(32'h0000_0013, 32'h0000_0003, 1'b0, 1'b0);
    count_ready(40, cnt);
    check("no_op_ignored", 32'(cnt), 32'd0);

    // Abort mid-operation; previous result (0xE) must be cleared.
    start(32'h0000_0011, 32'h0000_0003, 1'b1, 1'b0);
    repeat (9) begin
      @(posedge clock); #1;
    end
    reset = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    check("abort_ready", 32'(ready), 32'd0);
    check("abort_result", result, '0);
    count_ready(40, cnt);
    check("abort_no_pulse", 32'(cnt), 32'd0);
    run_op("restart_div", 32'h0000_0011, 32'h0000_0003, 1'b1, got);

    // Enable during CALC with different operands must be ignored.
    e.res = 32'h0000_000E;
    e.lat = 33;
    start(32'h0000_0013, 32'h0000_0003, 1'b1, 1'b0);
    sb.push_back(e);
    repeat (4) begin
      @(posedge clock); #1;
    end
    rdata1 = 32'h0000_0011;
    rdata2 = 32'h0000_0001;
    op_rem = 1'b1;
    enable = 1'b1;
    @(posedge clock); #1;
    enable = 1'b0;
    op_rem = 1'b0;
    finish_op("calc_enable", got);
    count_ready(40, cnt);
    check("calc_enable_no_extra", 32'(cnt), 32'd0);

    // Random operands, back-to-back requests.
    have_prev = 1'b0;
    prev_acc  = 0;
    for (int n = 0; n < 1000; n++) begin
      a = $urandom;
      b = $urandom >> $urandom_range(0, 31);
      if (b == '0) b = 32'h0000_0001;
      run_op("rnd_div", a, b, 1'b1, q);
      if (have_prev) check("b2b_div_spacing", 32'(acc_cyc - prev_acc), 32'd34);
      prev_acc  = acc_cyc;
      have_prev = 1'b1;
      run_op("rnd_rem", a, b, 1'b0, r);
      check("b2b_rem_spacing", 32'(acc_cyc - prev_acc), 32'd34);
      prev_acc = acc_cyc;
      check("rnd_identity", clmul(q, b) ^ r, a);
      check("rnd_deg", 32'(deg(r) < deg(b)), 32'd1);
    end

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
